// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-lane round-robin traffic light sequencer.
// Cycles ALL_RED -> GREEN -> YELLOW -> ALL_RED, with all timing on tick.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler #(
  parameter int GREEN_BASE  = 8,
  parameter int GREEN_EXT   = 4,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] lane_req,
  input  logic [3:0] lane_heavy,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic [1:0] emerg_lane,
`endif
  output logic [3:0] light_signal,
  output logic [1:0] active_lane,
  output logic       phase_done
);

  localparam int GREEN_MAX = GREEN_BASE + GREEN_EXT;
  localparam int MAX_A     = (GREEN_MAX > YELLOW_TIME) ? GREEN_MAX : YELLOW_TIME;
  localparam int MAX_DUR   = (MAX_A > ALLRED_TIME) ? MAX_A : ALLRED_TIME;
  localparam int TW        = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] green_last_q, green_last_d;  // latched green duration minus one
  logic [1:0]    lane_q, lane_d;
  logic [3:0]    light_q, light_d;
  logic          done_q, done_d;

  logic [1:0]    rr_lane;
  logic [1:0]    grant_lane;
  logic          grant_any;
  logic          other_req;
  logic          emerg_preempt;
  logic          emerg_hold;

  // Round-robin pick: first requesting lane after lane_q (lane_q itself is last).
  always_comb begin
    rr_lane = lane_q;
    for (int i = 4; i >= 1; i--) begin
      if (lane_req[lane_q + 2'(i)]) rr_lane = lane_q + 2'(i);
    end
  end

  assign other_req = |(lane_req & ~(4'b0001 << lane_q));

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_preempt = emerg_req && (lane_q != emerg_lane);
  assign emerg_hold    = emerg_req && (lane_q == emerg_lane);
  assign grant_any     = emerg_req || (|lane_req);
  assign grant_lane    = emerg_req ? emerg_lane : rr_lane;
`else
  assign emerg_preempt = 1'b0;
  assign emerg_hold    = 1'b0;
  assign grant_any     = |lane_req;
  assign grant_lane    = rr_lane;
`endif

  // Next-state, timer and registered-output computation; nothing moves without tick.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    lane_d       = lane_q;
    green_last_d = green_last_q;
    if (tick) begin
      unique case (state_q)
        ST_ALL_RED: begin
          if (timer_q == TW'(ALLRED_TIME - 1)) begin
            // Expired: grant if anyone waits, otherwise hold and retry each tick.
            if (grant_any) begin
              state_d      = ST_GREEN;
              timer_d      = '0;
              lane_d       = grant_lane;
              green_last_d = lane_heavy[grant_lane] ? TW'(GREEN_MAX - 1)
                                                    : TW'(GREEN_BASE - 1);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_GREEN: begin
          if (emerg_preempt) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end else if (!emerg_hold) begin
            if (timer_q == green_last_q) begin
              // Rest in green until some other lane wants the junction.
              if (other_req) begin
                state_d = ST_YELLOW;
                timer_d = '0;
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        ST_YELLOW: begin
          if (timer_q == TW'(YELLOW_TIME - 1)) begin
            state_d = ST_ALL_RED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_ALL_RED;
          timer_d = '0;
        end
      endcase
    end

    unique case (state_d)
      ST_GREEN:  light_d = {1'b0, lane_d, 1'b0} + 4'd1;
      ST_YELLOW: light_d = {1'b0, lane_d, 1'b0} + 4'd2;
      default:   light_d = 4'd0;
    endcase
    done_d = (state_d != state_q);
  end

  // State and output registers with synchronous reset into full all-red clearance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ALL_RED;
      timer_q      <= '0;
      lane_q       <= 2'd3;
      green_last_q <= TW'(GREEN_BASE - 1);
      light_q      <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lane_q       <= lane_d;
      green_last_q <= green_last_d;
      light_q      <= light_d;
      done_q       <= done_d;
    end
  end

  assign light_signal = light_q;
  assign active_lane  = lane_q;
  assign phase_done   = done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scoreboard bench for traffic_phase_scheduler (default parameters).
// Expected light codes are queued per clock; lane and phase_done are derived
// from the queued code sequence.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] lane_req = 4'd0;
  logic [3:0] lane_heavy = 4'd0;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_lane = 2'd0;
`endif
  logic [3:0] light_signal;
  logic [1:0] active_lane;
  logic       phase_done;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .lane_req    (lane_req),
    .lane_heavy  (lane_heavy),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req   (emerg_req),
    .emerg_lane  (emerg_lane),
`endif
    .light_signal(light_signal),
    .active_lane (active_lane),
    .phase_done  (phase_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] light;
    logic [1:0] lane;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         prev_code = 0;
  logic [1:0] prev_lane = 2'd3;

  function automatic int phase_class(input int code);
    if (code == 0) return 0;
    return (code % 2 == 1) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Queue n cycles of expected light code; lane and done follow from the code history.
  task automatic push(input int code, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.light   = 4'(code);
      e.lane    = (code == 0) ? prev_lane : 2'((code - 1) / 2);
      e.done    = (phase_class(code) != phase_class(prev_code));
      prev_code = code;
      prev_lane = e.lane;
      exp_q.push_back(e);
    end
  endtask

  // Clock n cycles with the given tick level, popping and comparing after each edge.
  task automatic run(input int n, input logic t);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      tick = t;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL scoreboard_empty: observed light %0d expected none queued", light_signal);
      end else begin
        e = exp_q.pop_front();
        check("light_signal", {4'd0, light_signal}, {4'd0, e.light});
        check("active_lane", {6'd0, active_lane}, {6'd0, e.lane});
        check("phase_done", {7'd0, phase_done}, {7'd0, e.done});
      end
    end
    tick = 1'b0;
  endtask

  task automatic do_reset(input logic t);
    rst  = 1'b1;
    tick = t;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    tick = 1'b0;
    prev_code = 0;
    prev_lane = 2'd3;
    check("rst_light", {4'd0, light_signal}, 8'd0);
    check("rst_lane", {6'd0, active_lane}, 8'd3);
    check("rst_done", {7'd0, phase_done}, 8'd0);
  endtask

  initial begin
    // Full round-robin cycle with every lane requesting, then tick-gated hold.
    do_reset(1'b0);
    lane_req = 4'b1111;
    push(0, 1); push(1, 8); push(2, 3); push(0, 2); push(3, 1);
    run(15, 1'b1);
    lane_req = 4'b0000;
    push(3, 5);
    run(5, 1'b0);

    // Heavy EW lane gets the extended green; a later heavy drop is ignored.
    do_reset(1'b0);
    lane_req   = 4'b0101;
    lane_heavy = 4'b0100;
    push(0, 1); push(1, 8); push(2, 3); push(0, 2);
    run(14, 1'b1);
    push(5, 12); push(6, 1);
    run(1, 1'b1);
    lane_heavy = 4'b0000;
    run(12, 1'b1);

    // Lone WE request rests in green until NS asks, then full yellow.
    do_reset(1'b0);
    lane_req = 4'b1000;
    push(0, 1); push(7, 12);
    run(13, 1'b1);
    lane_req = 4'b1001;
    push(8, 3); push(0, 2); push(1, 1);
    run(6, 1'b1);

    // No requests: all-red indefinitely, then an SN request is granted at once.
    do_reset(1'b0);
    lane_req = 4'b0000;
    push(0, 10);
    run(10, 1'b1);
    lane_req = 4'b0010;
    push(3, 1);
    run(1, 1'b1);

    // Reset during EW green restores defaults and NS is granted first.
    do_reset(1'b0);
    lane_req = 4'b0100;
    push(0, 1); push(5, 3);
    run(4, 1'b1);
    do_reset(1'b1);
    lane_req = 4'b1111;
    push(0, 1); push(1, 1);
    run(2, 1'b1);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency for EW during NS green: yellow, full all-red, then held EW green.
    do_reset(1'b0);
    lane_req = 4'b0001;
    push(0, 1); push(1, 3);
    run(4, 1'b1);
    emerg_req  = 1'b1;
    emerg_lane = 2'd2;
    push(2, 3); push(0, 2); push(5, 20);
    run(25, 1'b1);
    emerg_req = 1'b0;
    push(5, 7); push(6, 1);
    run(8, 1'b1);
`endif

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 The block SHALL have parameter GREEN_BASE, default 8: green duration in ticks for a normal lane.
REQ-002 The block SHALL have parameter GREEN_EXT, default 4: extra green ticks when the lane is heavy.
REQ-003 The block SHALL have parameter YELLOW_TIME, default 3: yellow duration in ticks.
REQ-004 The block SHALL have parameter ALLRED_TIME, default 2: minimum all-red clearance in ticks.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port tick, input, 1 bit: single-cycle timebase enable; all timers advance only on cycles where tick=1.
REQ-008 The block SHALL have port lane_req, input, 4 bits: vehicle-present flags; bit0 NS, bit1 SN, bit2 EW, bit3 WE.
REQ-009 The block SHALL have port lane_heavy, input, 4 bits: congestion flags, with the same bit order as lane_req.
REQ-010 The block SHALL have port light_signal, output, 4 bits, registered: phase code for the light driver.
REQ-011 The block SHALL have port active_lane, output, 2 bits, registered: the last lane granted green (0 NS, 1 SN, 2 EW, 3 WE).
REQ-012 The block SHALL have port phase_done, output, 1 bit, registered: one-cycle pulse on every state transition.

Function
REQ-013 The block SHALL drive light_signal with these codes: 0 = all red; green/yellow = 1/2 NS, 3/4 SN, 5/6 EW, 7/8 WE; codes 9-15 SHALL never be driven.
REQ-014 The block SHALL implement exactly three states: ALL_RED (code 0), GREEN and YELLOW, with the code selected by active_lane.
REQ-015 The block SHALL clear its internal timer on state entry, and on each tick SHALL either increment the timer or take the state exit when timer = duration-1; a state entered on a tick therefore lasts exactly its duration in ticks.
REQ-016 On ALL_RED expiry, if any lane_req bit is set, the block SHALL grant the first requesting lane in cyclic order after active_lane, set active_lane to it, and enter GREEN.
REQ-017 On ALL_RED expiry with lane_req = 0, the block SHALL remain in ALL_RED with the timer held, and SHALL re-evaluate REQ-016 on every later tick.
REQ-018 The block SHALL sample lane_heavy[granted lane] in the GREEN-entry cycle and latch a green duration of GREEN_BASE+GREEN_EXT if it is set, otherwise GREEN_BASE; later changes to lane_heavy SHALL not alter the latched duration.
REQ-019 On GREEN expiry, if any other lane requests, the block SHALL enter YELLOW.
REQ-020 On GREEN expiry with no other lane requesting, the block SHALL rest in green with the timer held at duration-1, and SHALL enter YELLOW on the first tick where another lane requests.
REQ-021 YELLOW SHALL always run its full YELLOW_TIME and then enter ALL_RED, regardless of the request inputs.
REQ-022 The block SHALL ignore request, heavy and timer activity in cycles where tick=0; state and outputs SHALL hold.
REQ-023 The block SHALL ensure that no two lanes are ever non-red simultaneously, and that every GREEN-to-GREEN handover passes through YELLOW and ALL_RED.
REQ-024 The block SHALL size its timer to hold GREEN_BASE+GREEN_EXT-1 and SHALL never wrap it.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL load state ALL_RED, light_signal 0, timer 0, active_lane 3 (so that NS is granted first) and phase_done 0.
REQ-026 An assertion of rst in any state, including mid-GREEN or mid-YELLOW, SHALL take effect on the next edge, and the ALL_RED clearance SHALL restart in full.

Configuration
REQ-027 The feature SHALL be controlled by the macro EMERGENCY_PREEMPT_EN; when it is defined, the block SHALL add input emerg_req (1 bit) and input emerg_lane (2 bits).
REQ-028 With EMERGENCY_PREEMPT_EN defined, an emerg_req seen while GREEN with active_lane ≠ emerg_lane SHALL force YELLOW on the next tick; ALL_RED expiry SHALL grant emerg_lane regardless of round-robin order; and while emerg_req=1 that green SHALL be held indefinitely.
REQ-029 With EMERGENCY_PREEMPT_EN defined, GREEN for emerg_lane SHALL resume normal timing once emerg_req drops, and preemption SHALL not shorten YELLOW or ALL_RED.
REQ-030 With EMERGENCY_PREEMPT_EN undefined, the emergency ports and logic SHALL be absent, and behaviour SHALL be exactly REQ-013 to REQ-024.

Verification
REQ-031 Reset then lane_req=4'b1111 with tick every cycle -> the bench SHALL see 0 for 2 ticks, 1 for 8, 2 for 3, 0 for 2, then 3.
REQ-032 lane_req=4'b0101 with lane_heavy[2]=1 -> the bench SHALL see NS green for 8 ticks, then EW green (code 5) for 12 ticks, then code 6.
REQ-033 Only lane_req[3]=1 -> the bench SHALL see code 7 held beyond 8 ticks; after lane_req[0] is raised, the next tick SHALL give code 8, followed by 3 ticks of yellow.
REQ-034 lane_req=0 after reset -> light_signal SHALL stay 0 indefinitely; raising lane_req[1] SHALL give code 3 on the next tick.
REQ-035 rst pulsed during code 5 -> the next cycle SHALL show light_signal 0 and active_lane 3, and NS SHALL be granted first.
REQ-036 With EMERGENCY_PREEMPT_EN defined, emerg_req=1 and emerg_lane=2 during NS green -> the bench SHALL see code 2 on the next tick, then 0 for 2 ticks, then code 5 held until emerg_req=0.
